// File: rtl/matrix_fetch_ctrl_pkg.sv
// Shared types and default dimensions for the matrix fetch controller,
// the GCN top that hosts it, and its bench.
package matrix_fetch_ctrl_pkg;

    localparam int MFC_FEATURE_COLS  = 96;
    localparam int MFC_FEATURE_ROWS  = 6;
    localparam int MFC_WEIGHT_COLS   = 3;
    localparam int MFC_DATA_WIDTH    = 5;
    localparam int MFC_ADDRESS_WIDTH = 13;
    localparam int MFC_FEATURE_BASE  = 512;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_W,
        ST_RD_F,
        ST_EMIT,
        ST_DONE
    } fetch_state_e;

    // Index width that stays legal when a dimension collapses to 1.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/matrix_fetch_ctrl_if.sv
// Memory read port plus consumer handshake of the matrix fetch controller.
// master = controller side, slave = memory/consumer side.
interface matrix_fetch_ctrl_if
    import matrix_fetch_ctrl_pkg::*;
#(
    parameter int FEATURE_COLS  = MFC_FEATURE_COLS,
    parameter int FEATURE_ROWS  = MFC_FEATURE_ROWS,
    parameter int WEIGHT_COLS   = MFC_WEIGHT_COLS,
    parameter int DATA_WIDTH    = MFC_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = MFC_ADDRESS_WIDTH
);
    localparam int W_IDX_W = idx_width(WEIGHT_COLS);
    localparam int F_IDX_W = idx_width(FEATURE_ROWS);

    logic                     start;
    logic [ADDRESS_WIDTH-1:0] read_address;
    logic                     enable_read;
    logic [DATA_WIDTH-1:0]    data_in     [0:FEATURE_COLS-1];
    logic [DATA_WIDTH-1:0]    weight_vec  [0:FEATURE_COLS-1];
    logic [DATA_WIDTH-1:0]    feature_vec [0:FEATURE_COLS-1];
    logic [W_IDX_W-1:0]       weight_idx;
    logic [F_IDX_W-1:0]       feature_idx;
    logic                     out_valid;
    logic                     out_ready;
    logic                     done;

    modport master (
        input  start, data_in, out_ready,
        output read_address, enable_read, weight_vec, feature_vec,
               weight_idx, feature_idx, out_valid, done
    );

    modport slave (
        output start, data_in, out_ready,
        input  read_address, enable_read, weight_vec, feature_vec,
               weight_idx, feature_idx, out_valid, done
    );

endinterface

// File: rtl/matrix_fetch_ctrl.sv
// Walks every (weight column, feature row) pair: one read per weight column,
// one read per feature row, then presents the buffered pair until accepted.
module matrix_fetch_ctrl
    import matrix_fetch_ctrl_pkg::*;
#(
    parameter int FEATURE_COLS  = MFC_FEATURE_COLS,
    parameter int FEATURE_ROWS  = MFC_FEATURE_ROWS,
    parameter int WEIGHT_COLS   = MFC_WEIGHT_COLS,
    parameter int DATA_WIDTH    = MFC_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = MFC_ADDRESS_WIDTH,
    parameter int FEATURE_BASE  = MFC_FEATURE_BASE
)(
    input  logic                  clk,
    input  logic                  reset,
    matrix_fetch_ctrl_if.master   bus
);
    localparam int W_IDX_W = idx_width(WEIGHT_COLS);
    localparam int F_IDX_W = idx_width(FEATURE_ROWS);

    fetch_state_e           state;
    logic [W_IDX_W-1:0]     w_idx;
    logic [F_IDX_W-1:0]     f_idx;
    logic [DATA_WIDTH-1:0]  w_buf [0:FEATURE_COLS-1];
    logic [DATA_WIDTH-1:0]  f_buf [0:FEATURE_COLS-1];

    function automatic logic [ADDRESS_WIDTH-1:0] feat_addr(input logic [F_IDX_W-1:0] r);
        return ADDRESS_WIDTH'(FEATURE_BASE) + ADDRESS_WIDTH'(r);
    endfunction

    function automatic logic [ADDRESS_WIDTH-1:0] wt_addr(input logic [W_IDX_W-1:0] c);
        return ADDRESS_WIDTH'(c);
    endfunction

    // Strobes and address are registered alongside the state so they are a
    // pure function of the current state, with no combinational path from inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= ST_IDLE;
            w_idx            <= '0;
            f_idx            <= '0;
            w_buf            <= '{default: '0};
            f_buf            <= '{default: '0};
            bus.enable_read  <= 1'b0;
            bus.read_address <= '0;
            bus.out_valid    <= 1'b0;
            bus.done         <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state            <= ST_RD_W;
                        w_idx            <= '0;
                        f_idx            <= '0;
                        bus.enable_read  <= 1'b1;
                        bus.read_address <= wt_addr('0);
                    end
                end
                ST_RD_W: begin
                    w_buf            <= bus.data_in;
                    state            <= ST_RD_F;
                    bus.read_address <= feat_addr(f_idx);
                end
                ST_RD_F: begin
                    f_buf            <= bus.data_in;
                    state            <= ST_EMIT;
                    bus.enable_read  <= 1'b0;
                    bus.read_address <= '0;
                    bus.out_valid    <= 1'b1;
                end
                ST_EMIT: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        if (f_idx < F_IDX_W'(FEATURE_ROWS - 1)) begin
                            f_idx            <= f_idx + 1'b1;
                            state            <= ST_RD_F;
                            bus.enable_read  <= 1'b1;
                            bus.read_address <= feat_addr(f_idx + 1'b1);
                        end else if (w_idx < W_IDX_W'(WEIGHT_COLS - 1)) begin
                            w_idx            <= w_idx + 1'b1;
                            f_idx            <= '0;
                            state            <= ST_RD_W;
                            bus.enable_read  <= 1'b1;
                            bus.read_address <= wt_addr(w_idx + 1'b1);
                        end else begin
                            state    <= ST_DONE;
                            bus.done <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    // Holding start keeps us here so a level request cannot retrigger a pass.
                    if (!bus.start) begin
                        state    <= ST_IDLE;
                        bus.done <= 1'b0;
                    end
                end
                default: begin
                    state            <= ST_IDLE;
                    bus.enable_read  <= 1'b0;
                    bus.read_address <= '0;
                    bus.out_valid    <= 1'b0;
                    bus.done         <= 1'b0;
                end
            endcase
        end
    end

    assign bus.weight_vec  = w_buf;
    assign bus.feature_vec = f_buf;
    assign bus.weight_idx  = w_idx;
    assign bus.feature_idx = f_idx;

endmodule
